pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
Sequences the program counter of the KGP-miniRISC core across a multi-cycle instruction-memory handshake. Each instruction is fetched at the current word-addressed PC, presented to decode with a valid/ready handshake, and the PC then advances to PC+1 or to a redirect target. It also handles stall, halt and fetch timeout. It sits between the PC register/incrementer path and the instruction memory and decode stage.

Parameters:
ADDR_W, 32, PC and instruction-memory address width (word address).
DATA_W, 32, instruction width.
RESET_PC, 0, PC value loaded on reset.
MAX_WAIT, 16, maximum FETCH cycles without imem_ack before error (>=2).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that leaves IDLE
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address, equal to pc while imem_req=1
imem_ack  in  1  memory response valid, sampled only in FETCH
imem_rdata  in  DATA_W  instruction word, valid with imem_ack
instr_valid  out  1  instruction presented to decode
instr  out  DATA_W  latched instruction
instr_pc  out  ADDR_W  PC of the presented instruction
instr_ready  in  1  decode accepts the instruction
stall  in  1  hazard stall that blocks acceptance
redirect_valid  in  1  branch/jump taken, sampled at accept
redirect_pc  in  ADDR_W  branch/jump target
halt  in  1  presented instruction is HALT, sampled at accept
pc  out  ADDR_W  current architectural PC
halted  out  1  core halted
fetch_err  out  1  sticky fetch-timeout error

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, pc=RESET_PC, wait_cnt=0. imem_req, instr_valid, halted and fetch_err are 0. instr and instr_pc are 0. Reset mid-fetch abandons the request immediately.
- States: IDLE, FETCH, ISSUE, HALTED, ERROR. All outputs are registered or decoded from state; there are no combinational paths from input to output except imem_addr=pc.
- IDLE: start=1 moves to FETCH on the next edge. Other inputs are ignored.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until ack.
  - On imem_ack: instr<=imem_rdata, instr_pc<=pc, state moves to ISSUE, wait_cnt<=0. imem_req drops in the following cycle. Latency from request to ack is at least 1 cycle.
  - Otherwise wait_cnt increments. If wait_cnt==MAX_WAIT-1 with no ack, state moves to ERROR.
  - An ack in the same cycle as the limit wins and the state moves to ISSUE.
- ISSUE:
  - instr_valid=1. accept = instr_valid & instr_ready & ~stall.
  - instr and instr_pc stay stable while not accepted.
  - On accept, the next PC is chosen as follows:
    - pc<=redirect_pc if redirect_valid is 1.
    - otherwise pc<=pc+1, modulo 2^ADDR_W, so 0xFFFFFFFF wraps to 0.
  - After accept, the next state is HALTED if halt=1, else FETCH.
  - With halt=1 and redirect_valid=1 together, the pc update still occurs and the state moves to HALTED.
  - instr_valid drops in the cycle after accept.
- HALTED: halted=1 and pc is frozen. start, imem_ack and redirect are ignored. Exit only via reset.
- ERROR: fetch_err=1 and imem_req=0. pc is frozen at the failing address. Exit only via reset.
- imem_ack outside FETCH is ignored and does not update instr.
- redirect_valid and halt outside an accept cycle have no effect.

Decomposition:
- Shared package: state encoding constants (IDLE=0, FETCH=1, ISSUE=2, HALTED=3, ERROR=4), 3-bit state width, and the RESET_PC default.
- One sub-module, pc_fetch_timer: a wait counter with clear, enable and a limit flag, parameterised by MAX_WAIT.
- The next-PC mux and the FSM stay in pc_fetch_sequencer.

Test Plan:
1. Reset, then start. Memory acks after 2 cycles with 0x12345678; decode ready=1. Required: imem_addr=0, instr=0x12345678, instr_pc=0; pc becomes 1 after accept; next fetch at address 1.
2. In ISSUE at pc=5, hold stall=1 for 3 cycles with ready=1. Required: instr_valid stays 1, instr stable, pc=5. Release stall: accept, pc=6.
3. At pc=8, accept with redirect_valid=1, redirect_pc=0x40. Required: pc=0x40, next imem_addr=0x40. Then force pc=0xFFFFFFFF with no redirect. Required: pc wraps to 0.
4. Accept with halt=1 at pc=3. Required: halted=1, pc=4, imem_req stays 0 thereafter. A later start pulse has no effect.
5. MAX_WAIT=16, no ack. Required: fetch_err=1 after exactly 16 FETCH cycles, imem_req=0, pc unchanged. Repeat with ack on cycle 16: ISSUE, no error.
6. Assert rst=0 mid-FETCH. Required: outputs clear immediately, pc=RESET_PC, state IDLE. An ack arriving after reset is ignored.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the KGP-miniRISC fetch sequencer: state encoding and
// the default reset program counter.
package pc_fetch_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_HALTED = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_timer.sv
// Fetch wait counter: counts FETCH cycles without an acknowledge and flags
// the cycle on which the last allowed wait is reached.
module pc_fetch_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic limit
);

    localparam int CNT_W = $clog2(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;

    assign limit = (wait_cnt == CNT_W'(MAX_WAIT - 1));

    // Count waiting cycles; clear wins, and the count parks at the limit.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // pre-edge values regardless of statement order.
        if (!rst) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (enable && !limit) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter fetch sequencer: fetches at pc over a req/ack memory
// handshake, presents the word to decode with valid/ready, then advances pc
// to pc+1 or a redirect target. Handles stall, halt and fetch timeout.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fetch_err
);

    state_t            state;
    logic              accept;
    logic              in_fetch;
    logic              wait_limit;
    logic [ADDR_W-1:0] next_pc;

    assign in_fetch  = (state == ST_FETCH);
    assign accept    = (state == ST_ISSUE) && instr_valid && instr_ready && !stall;
    assign next_pc   = redirect_valid ? redirect_pc : pc + ADDR_W'(1);
    assign imem_addr = pc;

    // The counter restarts whenever FETCH is left or answered, so every
    // fetch gets the full MAX_WAIT budget.
    pc_fetch_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_fetch || imem_ack),
        .enable (in_fetch),
        .limit  (wait_limit)
    );

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            halted      <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // An ack on the last allowed cycle still completes the fetch.
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ST_ISSUE;
                    end else if (wait_limit) begin
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= ST_ERROR;
                    end
                end
                ST_ISSUE: begin
                    if (accept) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= ST_HALTED;
                        end else begin
                            imem_req <= 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_HALTED, ST_ERROR: begin
                    state <= state;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: a reactive memory and decode
// driver feed a transaction-level reference model whose expected fetch
// addresses and issued instructions are checked by an independent monitor.
module tb_pc_fetch_sequencer;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          MAX_WAIT = 16;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk;
    logic              rst;
    logic              start;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              fetch_err;

    pc_fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .pc             (pc),
        .halted         (halted),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: word 0 holds 0x12345678, others are scrambled addresses.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_HALT, M_ERR} mmode_t;
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
    } issue_t;
    typedef struct packed {
        logic        ready;
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic        halt;
    } dec_t;

    mmode_t      m_mode;
    logic [31:0] m_pc;
    logic [31:0] exp_fetch[$];
    issue_t      exp_issue[$];
    dec_t        dec_plan[$];

    bit dec_random    = 0;
    int mem_lat_fixed = -1;
    bit junk_ack_en   = 1;
    bit junk_force    = 0;
    int n_accepts     = 0;

    function automatic dec_t mk_dec(input logic r, input logic s, input logic rd,
                                    input logic [31:0] t, input logic h);
        dec_t d;
        d.ready = r; d.stall = s; d.redirect = rd; d.target = t; d.halt = h;
        return d;
    endfunction

    // ---------------- memory + decode driver ----------------
    bit   mem_busy = 0;
    int   mem_cnt  = 0;
    dec_t cur_dec;

    always @(negedge clk) begin
        if (!rst) begin
            mem_busy       = 0;
            imem_ack       = junk_force;
            imem_rdata     = $urandom;
            instr_ready    = 1'b0;
            stall          = 1'b0;
            redirect_valid = 1'b0;
            halt           = 1'b0;
        end else begin
            // Memory: ack after a latency of at least one cycle.
            if (imem_req) begin
                if (!mem_busy) begin
                    mem_busy = 1;
                    mem_cnt  = (mem_lat_fixed >= 0) ? mem_lat_fixed : int'($urandom_range(1, 4));
                end else begin
                    mem_cnt--;
                end
                imem_ack = (mem_cnt == 0);
                if (imem_ack) begin
                    imem_rdata = mem_word(imem_addr);
                    exp_issue.push_back({mem_word(m_pc), m_pc});
                end else begin
                    imem_rdata = $urandom;
                end
            end else begin
                mem_busy   = 0;
                imem_ack   = junk_force || (junk_ack_en && $urandom_range(0, 5) == 0);
                imem_rdata = $urandom;
            end

            // Decode: follow the plan, else random, else hold off.
            if (instr_valid) begin
                if (dec_plan.size() > 0) begin
                    cur_dec = dec_plan.pop_front();
                end else if (dec_random) begin
                    cur_dec.ready    = ($urandom_range(0, 3) != 0);
                    cur_dec.stall    = ($urandom_range(0, 3) == 0);
                    cur_dec.redirect = ($urandom_range(0, 3) == 0);
                    case ($urandom_range(0, 3))
                        0:       cur_dec.target = 32'hFFFF_FFFF;
                        1:       cur_dec.target = 32'h0000_0040;
                        default: cur_dec.target = $urandom;
                    endcase
                    cur_dec.halt = ($urandom_range(0, 49) == 0);
                end else begin
                    cur_dec = mk_dec(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
                end
                instr_ready    = cur_dec.ready;
                stall          = cur_dec.stall;
                redirect_valid = cur_dec.redirect;
                redirect_pc    = cur_dec.target;
                halt           = cur_dec.halt;
                if (cur_dec.ready && !cur_dec.stall) begin
                    n_accepts++;
                    m_pc = cur_dec.redirect ? cur_dec.target : m_pc + 32'd1;
                    if (cur_dec.halt) m_mode = M_HALT;
                    else              exp_fetch.push_back(m_pc);
                end
            end else begin
                // Junk on decode-side inputs outside ISSUE must be ignored.
                instr_ready    = $urandom_range(0, 1);
                stall          = $urandom_range(0, 1);
                redirect_valid = $urandom_range(0, 1);
                redirect_pc    = $urandom;
                halt           = $urandom_range(0, 1);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic   prev_req   = 1'b0;
    logic   prev_valid = 1'b0;
    issue_t cur_issue;
    issue_t exp_i;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            check("pc", pc, m_pc);
            check("halted", halted, (m_mode == M_HALT));
            if (m_mode == M_HALT || m_mode == M_IDLE) begin
                check("req_quiet", imem_req, 1'b0);
                check("valid_quiet", instr_valid, 1'b0);
            end
            if (imem_req && !prev_req) begin
                if (exp_fetch.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fetch_unexpected: got request at %0h, required none", imem_addr);
                end else begin
                    check("fetch_addr", imem_addr, exp_fetch.pop_front());
                end
            end
            if (instr_valid && !prev_valid) begin
                if (exp_issue.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL issue_unexpected: got instr %0h at %0h, required none", instr, instr_pc);
                    cur_issue = {instr, instr_pc};
                end else begin
                    exp_i     = exp_issue.pop_front();
                    cur_issue = exp_i;
                end
            end
            if (instr_valid) begin
                check("instr", instr, cur_issue.data);
                check("instr_pc", instr_pc, cur_issue.addr);
            end
        end
        prev_req   = imem_req;
        prev_valid = instr_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic model_reset();
        exp_fetch.delete();
        exp_issue.delete();
        dec_plan.delete();
        m_pc   = RESET_PC;
        m_mode = M_IDLE;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_pc", pc, RESET_PC);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_halted", halted, 1'b0);
        check("rst_err", fetch_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        if (m_mode == M_IDLE) begin
            exp_fetch.push_back(m_pc);
            m_mode = M_RUN;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_accepts(input int target, input int bound);
        for (int i = 0; i < bound && n_accepts < target; i++) @(negedge clk);
        checks++;
        if (n_accepts < target) begin
            errors++;
            $display("FAIL accept_timeout: got %0d accepts, required %0d", n_accepts, target);
        end
    endtask

    task automatic plan_plain(input int n);
        for (int i = 0; i < n; i++) dec_plan.push_back(mk_dec(1'b1, 1'b0, 1'b0, 32'h0, 1'b0));
    endtask

    // Watchdog: a hung run still reports.
    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        rst   = 1'b0;
        start = 1'b0;
        model_reset();

        // 1: basic fetch/issue/advance.
        do_reset();
        mem_lat_fixed = 2;
        plan_plain(1);
        do_start();
        wait_accepts(1, 50);
        repeat (12) @(negedge clk);
        check("t1_valid", instr_valid, 1'b1);
        check("t1_instr_pc", instr_pc, 32'h1);
        check("t1_instr", instr, mem_word(32'h1));
        check("t1_pc", pc, 32'h1);

        // 2: stall at pc=5 (redirect/halt during stall must be ignored).
        mem_lat_fixed = -1;
        plan_plain(4);
        for (int i = 0; i < 3; i++) dec_plan.push_back(mk_dec(1'b1, 1'b1, 1'b1, 32'h77, 1'b1));
        plan_plain(1);
        base = n_accepts;
        wait_accepts(base + 5, 200);
        repeat (10) @(negedge clk);
        check("t2_pc", pc, 32'h6);

        // 3: redirect at pc=8 to 0x40, then to 0xFFFFFFFF, then wrap to 0.
        plan_plain(2);
        dec_plan.push_back(mk_dec(1'b1, 1'b0, 1'b1, 32'h40, 1'b0));
        dec_plan.push_back(mk_dec(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0));
        plan_plain(1);
        base = n_accepts;
        wait_accepts(base + 5, 200);
        repeat (10) @(negedge clk);
        check("t3_wrap_pc", pc, 32'h0);
        check("t3_instr_pc", instr_pc, 32'h0);

        // 4: halt at pc=3; later start is ignored.
        do_reset();
        plan_plain(3);
        dec_plan.push_back(mk_dec(1'b1, 1'b0, 1'b0, 32'h0, 1'b1));
        do_start();
        wait_accepts(n_accepts + 4, 200);
        repeat (5) @(negedge clk);
        check("t4_halted", halted, 1'b1);
        check("t4_pc", pc, 32'h4);
        do_start();
        repeat (10) @(negedge clk);
        check("t4_req", imem_req, 1'b0);
        check("t4_pc_frozen", pc, 32'h4);

        // Randomized traffic, several runs each ending in halt or a budget.
        dec_random = 1;
        base = n_accepts;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            do_start();
            for (int i = 0; i < 400 && m_mode != M_HALT; i++) @(negedge clk);
        end
        dec_random = 0;
        checks++;
        if (n_accepts - base < 30) begin
            errors++;
            $display("FAIL random_progress: got %0d accepts, required at least 30", n_accepts - base);
        end

        // 5a: no ack -> error after exactly MAX_WAIT FETCH cycles.
        do_reset();
        mem_lat_fixed = 1000;
        @(negedge clk);
        start = 1'b1;
        exp_fetch.push_back(m_pc);
        m_mode = M_RUN;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (fetch_err) break;
            if (imem_req) n++;
        end
        m_mode = M_ERR;
        check("t5_wait_cycles", n, MAX_WAIT);
        check("t5_err", fetch_err, 1'b1);
        check("t5_req", imem_req, 1'b0);
        repeat (5) @(negedge clk);
        check("t5_err_sticky", fetch_err, 1'b1);
        check("t5_pc", pc, 32'h0);

        // 5b: ack on the last allowed cycle wins.
        do_reset();
        mem_lat_fixed = MAX_WAIT - 1;
        @(negedge clk);
        start = 1'b1;
        exp_fetch.push_back(m_pc);
        m_mode = M_RUN;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (fetch_err || instr_valid) break;
            if (imem_req) n++;
        end
        check("t5b_wait_cycles", n, MAX_WAIT);
        check("t5b_valid", instr_valid, 1'b1);
        check("t5b_err", fetch_err, 1'b0);

        // 6: reset in the middle of a fetch, then stray acks in IDLE.
        do_reset();
        mem_lat_fixed = -1;
        plan_plain(1);
        do_start();
        wait_accepts(n_accepts + 1, 50);
        mem_lat_fixed = 1000;
        for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("t6_req", imem_req, 1'b0);
        check("t6_pc", pc, RESET_PC);
        check("t6_valid", instr_valid, 1'b0);
        check("t6_instr", instr, 32'h0);
        check("t6_instr_pc", instr_pc, 32'h0);
        junk_force = 1;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_idle_req", imem_req, 1'b0);
        check("t6_idle_valid", instr_valid, 1'b0);
        check("t6_idle_instr", instr, 32'h0);
        junk_force = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
